// File: rtl/mult_div_unit_if.sv
// Bus between the pipeline and the multiply/divide unit: operands and
// MTHI/MTLO strobes from the pipeline, handshake and HI/LO back.
interface mult_div_unit_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic [1:0]        op;
  logic [DATA_W-1:0] sourceReg;
  logic [DATA_W-1:0] secondaryReg;
  logic              hiWrite;
  logic              loWrite;
  logic [DATA_W-1:0] writeData;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  modport master (
    output start, op, sourceReg, secondaryReg, hiWrite, loWrite, writeData,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, sourceReg, secondaryReg, hiWrite, loWrite, writeData,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Multicycle MULT/MULTU/DIV/DIVU engine with HI/LO registers.
// Works on operand magnitudes (shift-add multiply, restoring divide, one bit
// per cycle) and applies the sign correction in a single FIX cycle.
module mult_div_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input logic            Clk,
  input logic            Reset_n,
  mult_div_unit_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

  logic [1:0]        state;
  logic [CNT_W-1:0]  count;
  logic              busyReg;
  logic              doneReg;

  logic              isDiv;
  logic              negResult;
  logic              negRem;
  logic              divZero;
  logic [DATA_W-1:0] opB;
  logic [DATA_W-1:0] accHi;
  logic [DATA_W-1:0] accLo;
  logic [DATA_W-1:0] hiReg;
  logic [DATA_W-1:0] loReg;

  logic signed [DATA_W-1:0] rsSigned;
  logic signed [DATA_W-1:0] rtSigned;
  logic              opSigned;
  logic              signA;
  logic              signB;
  logic [DATA_W-1:0] magA;
  logic [DATA_W-1:0] magB;

  logic [DATA_W:0]   mulSum;
  logic [DATA_W:0]   divShift;
  logic              divGe;
  logic [DATA_W-1:0] divRem;

  logic [2*DATA_W-1:0] product;
  logic [DATA_W-1:0]   fixHi;
  logic [DATA_W-1:0]   fixLo;

  function automatic logic [DATA_W-1:0] absVal(input logic signed [DATA_W-1:0] v);
    return v[DATA_W-1] ? DATA_W'(-v) : DATA_W'(v);
  endfunction

  function automatic logic [DATA_W-1:0] negIf(input logic [DATA_W-1:0] v, input logic neg);
    return neg ? DATA_W'(-v) : v;
  endfunction

  function automatic logic [2*DATA_W-1:0] negWideIf(input logic [2*DATA_W-1:0] v,
                                                     input logic neg);
    return neg ? (2*DATA_W)'(-v) : v;
  endfunction

  assign rsSigned = bus.sourceReg;
  assign rtSigned = bus.secondaryReg;

  // Operand magnitudes and result signs captured when an operation is accepted
  always_comb begin
    opSigned = ~bus.op[0];
    signA    = opSigned & bus.sourceReg[DATA_W-1];
    signB    = opSigned & bus.secondaryReg[DATA_W-1];
    magA     = opSigned ? absVal(rsSigned) : bus.sourceReg;
    magB     = opSigned ? absVal(rtSigned) : bus.secondaryReg;
  end

  // One multiply or divide step on the magnitude registers
  always_comb begin
    mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, opB} : (DATA_W+1)'(0));
    divShift = {accHi, accLo[DATA_W-1]};
    divGe    = (divShift >= {1'b0, opB});
    divRem   = divGe ? DATA_W'(divShift - {1'b0, opB}) : divShift[DATA_W-1:0];
  end

  // Sign correction and the divide-by-zero override; the most-negative / -1
  // divide falls out naturally (magnitude quotient negated back to itself)
  always_comb begin
    product = negWideIf({accHi, accLo}, negResult);
    if (isDiv) begin
      fixHi = negIf(accHi, negRem);
      fixLo = divZero ? '1 : negIf(accLo, negResult);
    end else begin
      fixHi = product[2*DATA_W-1:DATA_W];
      fixLo = product[DATA_W-1:0];
    end
  end

  // Control FSM: IDLE -> CALC for DATA_W steps -> FIX -> IDLE
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= IDLE;
      count   <= '0;
      busyReg <= 1'b0;
      doneReg <= 1'b0;
    end else begin
      doneReg <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state   <= CALC;
            busyReg <= 1'b1;
            count   <= '0;
          end
        end
        CALC: begin
          count <= count + CNT_W'(1);
          if (count == LAST_ITER) state <= FIX;
        end
        FIX: begin
          state   <= IDLE;
          busyReg <= 1'b0;
          doneReg <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          busyReg <= 1'b0;
        end
      endcase
    end
  end

  // Operand latch on accept, then shift-add / restoring-divide iterations
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      isDiv     <= 1'b0;
      negResult <= 1'b0;
      negRem    <= 1'b0;
      divZero   <= 1'b0;
      opB       <= '0;
      accHi     <= '0;
      accLo     <= '0;
    end else if (state == IDLE && bus.start) begin
      isDiv     <= bus.op[1];
      negResult <= signA ^ signB;
      negRem    <= signA;
      divZero   <= bus.op[1] & (bus.secondaryReg == '0);
      opB       <= bus.op[1] ? magB : magA;
      accLo     <= bus.op[1] ? magA : magB;
      accHi     <= '0;
    end else if (state == CALC) begin
      if (isDiv) begin
        accHi <= divRem;
        accLo <= {accLo[DATA_W-2:0], divGe};
      end else begin
        accHi <= mulSum[DATA_W:1];
        accLo <= {mulSum[0], accLo[DATA_W-1:1]};
      end
    end
  end

  // HI/LO: result write from FIX, MTHI/MTLO only when idle and not starting
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hiReg <= '0;
      loReg <= '0;
    end else if (state == FIX) begin
      hiReg <= fixHi;
      loReg <= fixLo;
    end else if (state == IDLE && !bus.start) begin
      if (bus.hiWrite) hiReg <= bus.writeData;
      if (bus.loWrite) loReg <= bus.writeData;
    end
  end

  assign bus.busy = busyReg;
  assign bus.done = doneReg;
  assign bus.hi   = hiReg;
  assign bus.lo   = loReg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: a cycle-count/arithmetic reference model checked
// against the DUT on every falling edge, plus directed literal checks.
module tb_mult_div_unit;

  localparam int DATA_W = 32;

  logic Clk     = 1'b0;
  logic Reset_n = 1'b0;

  mult_div_unit_if #(.DATA_W(DATA_W)) bus();

  mult_div_unit #(.DATA_W(DATA_W), .CNT_W(6)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  always #5 Clk = ~Clk;

  int   nChecks = 0;
  int   nFail   = 0;
  logic checkEn = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result {hi, lo} from plain arithmetic
  function automatic logic [63:0] refResult(input logic [1:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    int     sa, sb;
    longint p;
    logic [31:0] q, r;
    sa = $signed(a);
    sb = $signed(b);
    case (o)
      2'b00: begin
        p = longint'(sa) * longint'(sb);
        return p;
      end
      2'b01: return {32'b0, a} * {32'b0, b};
      2'b10: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, a};
        q = sa / sb;
        r = sa % sb;
        return {r, q};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Reference model: busy for DATA_W+1 cycles after accept, then result and done
  logic        mBusy = 1'b0;
  logic        mDone = 1'b0;
  logic [31:0] mHi   = '0;
  logic [31:0] mLo   = '0;
  logic [63:0] pend  = '0;
  int          cnt   = 0;

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      mBusy <= 1'b0;
      mDone <= 1'b0;
      mHi   <= '0;
      mLo   <= '0;
      pend  <= '0;
      cnt   <= 0;
    end else begin
      mDone <= 1'b0;
      if (mBusy) begin
        cnt <= cnt - 1;
        if (cnt == 1) begin
          mBusy <= 1'b0;
          mDone <= 1'b1;
          mHi   <= pend[63:32];
          mLo   <= pend[31:0];
        end
      end else if (bus.start) begin
        mBusy <= 1'b1;
        cnt   <= DATA_W + 1;
        pend  <= refResult(bus.op, bus.sourceReg, bus.secondaryReg);
      end else begin
        if (bus.hiWrite) mHi <= bus.writeData;
        if (bus.loWrite) mLo <= bus.writeData;
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge Clk) begin
    if (checkEn) begin
      check("cyc_busy", 64'(bus.busy), 64'(mBusy));
      check("cyc_done", 64'(bus.done), 64'(mDone));
      check("cyc_hi",   64'(bus.hi),   64'(mHi));
      check("cyc_lo",   64'(bus.lo),   64'(mLo));
    end
  end

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    bus.start        = 1'b1;
    bus.op           = o;
    bus.sourceReg    = a;
    bus.secondaryReg = b;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic waitDone(output int cyc, output int bcyc);
    cyc  = 0;
    bcyc = 0;
    while (bus.done !== 1'b1 && cyc < 80) begin
      if (bus.busy === 1'b1) bcyc++;
      tick();
      cyc++;
    end
    check("done_seen", 64'(bus.done), 64'd1);
  endtask

  int cyc, bcyc, doneCount;

  initial begin
    bus.start        = 1'b0;
    bus.op           = 2'b00;
    bus.sourceReg    = '0;
    bus.secondaryReg = '0;
    bus.hiWrite      = 1'b0;
    bus.loWrite      = 1'b0;
    bus.writeData    = '0;
    Reset_n          = 1'b0;
    repeat (2) tick();

    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_hi",   64'(bus.hi),   64'd0);
    check("rst_lo",   64'(bus.lo),   64'd0);
    Reset_n = 1'b1;
    checkEn = 1'b1;
    tick();

    check("ref_mult",   refResult(2'b00, 32'd7, 32'hFFFF_FFFD), 64'hFFFF_FFFF_FFFF_FFEB);
    check("ref_divovf", refResult(2'b10, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);
    check("ref_div",    refResult(2'b10, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);

    // MULT 7 x -3
    issue(2'b00, 32'd7, 32'hFFFF_FFFD);
    waitDone(cyc, bcyc);
    check("mult_latency", 64'(cyc), 64'd33);
    check("mult_hi", 64'(bus.hi), 64'hFFFF_FFFF);
    check("mult_lo", 64'(bus.lo), 64'hFFFF_FFEB);
    tick();
    check("mult_done_pulse", 64'(bus.done), 64'd0);

    // MULTU max x max
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    waitDone(cyc, bcyc);
    check("multu_busy_cycles", 64'(bcyc), 64'd33);
    check("multu_hi", 64'(bus.hi), 64'hFFFF_FFFE);
    check("multu_lo", 64'(bus.lo), 64'h0000_0001);
    tick();

    // DIV -7 / 2
    issue(2'b10, 32'hFFFF_FFF9, 32'd2);
    waitDone(cyc, bcyc);
    check("div_lo", 64'(bus.lo), 64'hFFFF_FFFD);
    check("div_hi", 64'(bus.hi), 64'hFFFF_FFFF);
    tick();

    // DIV most-negative / -1
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    waitDone(cyc, bcyc);
    check("divovf_lo", 64'(bus.lo), 64'h8000_0000);
    check("divovf_hi", 64'(bus.hi), 64'h0000_0000);
    tick();

    // DIVU 100 / 0 with an ignored second start mid-operation
    issue(2'b11, 32'd100, 32'd0);
    repeat (5) tick();
    bus.start        = 1'b1;
    bus.op           = 2'b01;
    bus.sourceReg    = 32'd3;
    bus.secondaryReg = 32'd3;
    tick();
    bus.start = 1'b0;
    waitDone(cyc, bcyc);
    check("divz_lo", 64'(bus.lo), 64'hFFFF_FFFF);
    check("divz_hi", 64'(bus.hi), 64'h0000_0064);
    tick();
    check("divz_no_queue", 64'(bus.busy), 64'd0);

    // Reset in the middle of a DIVU
    issue(2'b11, 32'd1000, 32'd7);
    repeat (10) tick();
    Reset_n = 1'b0;
    #1;
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_hi",   64'(bus.hi),   64'd0);
    check("midrst_lo",   64'(bus.lo),   64'd0);
    tick();
    Reset_n   = 1'b1;
    doneCount = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done === 1'b1) doneCount++;
      tick();
    end
    check("midrst_no_done", 64'(doneCount), 64'd0);
    issue(2'b11, 32'd1000, 32'd7);
    waitDone(cyc, bcyc);
    check("after_rst_lo", 64'(bus.lo), 64'd142);
    check("after_rst_hi", 64'(bus.hi), 64'd6);
    tick();

    // MTLO, then MTHI+MTLO together while idle
    bus.loWrite   = 1'b1;
    bus.writeData = 32'h1234_5678;
    tick();
    bus.loWrite = 1'b0;
    check("mtlo", 64'(bus.lo), 64'h1234_5678);
    bus.hiWrite   = 1'b1;
    bus.loWrite   = 1'b1;
    bus.writeData = 32'hAAAA_5555;
    tick();
    bus.hiWrite = 1'b0;
    bus.loWrite = 1'b0;
    check("mtboth_hi", 64'(bus.hi), 64'hAAAA_5555);
    check("mtboth_lo", 64'(bus.lo), 64'hAAAA_5555);

    // MTHI together with start and during busy is ignored
    bus.hiWrite   = 1'b1;
    bus.writeData = 32'hDEAD_BEEF;
    issue(2'b01, 32'd3, 32'd5);
    repeat (5) tick();
    check("mthi_busy_hi", 64'(bus.hi), 64'hAAAA_5555);
    bus.hiWrite = 1'b0;
    waitDone(cyc, bcyc);
    check("multu35_hi", 64'(bus.hi), 64'd0);
    check("multu35_lo", 64'(bus.lo), 64'd15);

    // Back-to-back: start in the done cycle is accepted
    issue(2'b10, 32'hFFFF_FF9C, 32'd7);
    check("b2b_busy", 64'(bus.busy), 64'd1);
    waitDone(cyc, bcyc);
    check("b2b_latency", 64'(cyc), 64'd33);
    check("b2b_lo", 64'(bus.lo), 64'hFFFF_FFF2);
    check("b2b_hi", 64'(bus.hi), 64'hFFFF_FFFE);
    repeat (3) tick();

    checkEn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
